// File: rtl/wm_haar_block_extractor.sv
// Blind watermark extractor: one Haar subband coefficient per 2x2 block is compared
// between watermarked and host pixels; the scaled, saturated difference is one output sample.
module wm_haar_block_extractor #(
    parameter int PIXEL_WIDTH      = 8,
    parameter int INV_GAIN         = 100,
    parameter int BLOCKS_PER_FRAME = 16384
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             subband_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] wm_pix,
    input  logic [PIXEL_WIDTH-1:0] host_pix,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_WIDTH-1:0] out_data,
    output logic                   busy,
    output logic                   done
);

    localparam int SUM_W  = PIXEL_WIDTH + 3;
    localparam int DIFF_W = PIXEL_WIDTH + 4;
    localparam int GAIN_W = 11;
    localparam int PROD_W = DIFF_W + GAIN_W;
    localparam int BLK_W  = $clog2(BLOCKS_PER_FRAME + 1);

    localparam logic [BLK_W-1:0]         LAST_BLK = BLK_W'(BLOCKS_PER_FRAME - 1);
    localparam logic signed [PROD_W-1:0] GAIN_EXT = PROD_W'(INV_GAIN);
    localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'((1 << PIXEL_WIDTH) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state_reg, state_next;
    logic [1:0]               sel_reg;
    logic [1:0]               beat_reg;
    logic [BLK_W-1:0]         blk_reg;
    logic                     out_valid_reg;
    logic [PIXEL_WIDTH-1:0]   out_data_reg;

    logic                     frame_start;
    logic                     beat_fire;
    logic                     last_beat;
    logic                     out_fire;
    logic                     neg_term;
    logic [PIXEL_WIDTH-1:0]   pix_in [2];
    logic signed [SUM_W-1:0]  coef [2];
    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] prod;
    logic [PIXEL_WIDTH-1:0]   sat_data;

    assign frame_start = (state_reg == S_IDLE) && start;
    assign in_ready    = (state_reg == S_RUN) &&
                         !((beat_reg == 2'd3) && out_valid_reg && !out_ready);
    assign beat_fire   = in_valid && in_ready;
    assign last_beat   = beat_fire && (beat_reg == 2'd3);
    assign out_fire    = out_valid_reg && out_ready;

    // beat[0] is the column, beat[1] the row; HL negates odd columns, LH odd rows, HH both.
    assign neg_term = (sel_reg[0] & beat_reg[0]) ^ (sel_reg[1] & beat_reg[1]);

    assign pix_in[0] = wm_pix;
    assign pix_in[1] = host_pix;

    // Lane 0 accumulates the watermarked block, lane 1 the host block.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic signed [SUM_W-1:0] sum_reg;
            logic signed [SUM_W-1:0] pix_ext;
            logic signed [SUM_W-1:0] sum_next;

            assign pix_ext  = $signed({3'b000, pix_in[gi]});
            assign sum_next = sum_reg + (neg_term ? -pix_ext : pix_ext);
            assign coef[gi] = sum_next >>> 2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_reg <= '0;
                end else if (frame_start || last_beat) begin
                    sum_reg <= '0;
                end else if (beat_fire) begin
                    sum_reg <= sum_next;
                end
            end
        end
    endgenerate

    assign diff = DIFF_W'(coef[0]) - DIFF_W'(coef[1]);
    assign prod = PROD_W'(diff) * GAIN_EXT;

    always_comb begin
        sat_data = prod[PIXEL_WIDTH-1:0];
        if (prod[PROD_W-1]) begin
            sat_data = '0;
        end else if (prod > SAT_MAX) begin
            sat_data = '1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_beat && (blk_reg == LAST_BLK)) state_next = S_DRAIN;
            S_DRAIN: if (out_fire) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            sel_reg   <= '0;
            beat_reg  <= '0;
            blk_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (frame_start) begin
                sel_reg  <= subband_sel;
                beat_reg <= '0;
                blk_reg  <= '0;
            end else begin
                if (beat_fire) beat_reg <= beat_reg + 2'd1;
                if (last_beat) blk_reg <= blk_reg + BLK_W'(1);
            end
        end
    end

    // One-entry output register; a new sample may load on the same edge the old one drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (last_beat) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= sat_data;
        end else if (out_fire) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);

endmodule

// File: tb/tb_wm_haar_block_extractor.sv
// Scoreboard bench for wm_haar_block_extractor with INV_GAIN=4, BLOCKS_PER_FRAME=4.
module tb_wm_haar_block_extractor;

    localparam int P  = 8;
    localparam int G  = 4;
    localparam int NB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   subband_sel;
    logic         in_valid;
    logic         in_ready;
    logic [P-1:0] wm_pix;
    logic [P-1:0] host_pix;
    logic         out_valid;
    logic         out_ready;
    logic [P-1:0] out_data;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    wm_haar_block_extractor #(
        .PIXEL_WIDTH(P),
        .INV_GAIN(G),
        .BLOCKS_PER_FRAME(NB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .subband_sel(subband_sel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wm_pix(wm_pix),
        .host_pix(host_pix),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy),
        .done(done)
    );

    int n_run  = 0;
    int n_fail = 0;
    int exp_q[$];
    int done_cnt = 0;
    int bw[NB][4];
    int bh[NB][4];
    int stall_log[NB*4];

    task automatic check(input string tag, input int obs, input int exp);
        n_run++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    function automatic int coef(input int sel, input int a, input int b, input int c, input int d);
        int s;
        case (sel)
            0:       s = a + b + c + d;
            1:       s = a - b + c - d;
            2:       s = a + b - c - d;
            default: s = a - b - c + d;
        endcase
        return s >>> 2;
    endfunction

    function automatic int model(input int sel, input int k);
        int p;
        p = (coef(sel, bw[k][0], bw[k][1], bw[k][2], bw[k][3]) -
             coef(sel, bh[k][0], bh[k][1], bh[k][2], bh[k][3])) * G;
        if (p < 0) return 0;
        if (p > 255) return 255;
        return p;
    endfunction

    task automatic fill_rand(input int k);
        for (int j = 0; j < 4; j++) begin
            bw[k][j] = int'($urandom_range(0, 255));
            bh[k][j] = int'($urandom_range(0, 255));
        end
    endtask

    // Monitor: counts done pulses and retires samples against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && done) done_cnt++;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
                else check("sample", int'(out_data), exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic drive_beat(input int w, input int h, output int stalls);
        stalls   = 0;
        in_valid = 1'b1;
        wm_pix   = P'(w);
        host_pix = P'(h);
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            stalls++;
            if (stalls > 200) begin
                check("in_ready_timeout", int'(in_ready), 1);
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input int sel);
        subband_sel = 2'(sel);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        subband_sel = 2'(~sel);
    endtask

    task automatic run_frame(input int sel);
        int st;
        int d0;
        d0 = done_cnt;
        pulse_start(sel);
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < 4; j++) begin
                drive_beat(bw[k][j], bh[k][j], st);
                stall_log[k*4+j] = st;
            end
            if (k == 0) begin
                check("lat_valid", int'(out_valid), 1);
                check("lat_data", int'(out_data), model(sel, 0));
            end
            exp_q.push_back(model(sel, k));
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) break;
        end
        repeat (3) @(negedge clk);
        #1;
        check("done_once", done_cnt - d0, 1);
        check("idle_busy", int'(busy), 0);
        check("sb_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        int sum;
        int cap;
        int d0;
        rst         = 1'b1;
        start       = 1'b0;
        subband_sel = 2'd0;
        in_valid    = 1'b0;
        wm_pix      = '0;
        host_pix    = '0;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // LL, constant blocks: 100 vs 96 gives 16 per sample, no stalls.
        for (int k = 0; k < NB; k++)
            for (int j = 0; j < 4; j++) begin
                bw[k][j] = 100;
                bh[k][j] = 96;
            end
        run_frame(0);
        sum = 0;
        for (int i = 0; i < NB*4; i++) sum += stall_log[i];
        check("ll_stalls", sum, 0);

        // HH: checkerboard gives 20; inverse checkerboard clamps to 0.
        bw[0] = '{10, 0, 0, 10};  bh[0] = '{0, 0, 0, 0};
        bw[1] = '{0, 10, 10, 0};  bh[1] = '{0, 0, 0, 0};
        fill_rand(2);
        fill_rand(3);
        run_frame(3);

        // LL saturation at both ends.
        bw[0] = '{255, 255, 255, 255}; bh[0] = '{0, 0, 0, 0};
        bw[1] = '{0, 0, 0, 0};         bh[1] = '{200, 200, 200, 200};
        fill_rand(2);
        fill_rand(3);
        run_frame(0);

        // HL random frame.
        for (int k = 0; k < NB; k++) fill_rand(k);
        run_frame(1);

        // LH with output backpressure for 10 cycles after the first sample.
        for (int k = 0; k < NB; k++) fill_rand(k);
        out_ready = 1'b0;
        fork
            run_frame(2);
            begin
                for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
                cap = int'(out_data);
                repeat (10) @(negedge clk);
                check("bp_hold_valid", int'(out_valid), 1);
                check("bp_hold_data", int'(out_data), cap);
                check("bp_in_ready", int'(in_ready), 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("bp_stalled", int'(stall_log[7] > 0), 1);
        sum = 0;
        for (int i = 8; i < NB*4; i++) sum += stall_log[i];
        check("bp_release_stalls", sum, 0);

        // HL frame: start mid-frame is ignored, reset after 6 beats aborts.
        bw[0] = '{60, 50, 70, 40}; bh[0] = '{50, 40, 30, 60};
        fill_rand(1);
        pulse_start(1);
        drive_beat(bw[0][0], bh[0][0], st);
        drive_beat(bw[0][1], bh[0][1], st);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("run_busy", int'(busy), 1);
        drive_beat(bw[0][2], bh[0][2], st);
        drive_beat(bw[0][3], bh[0][3], st);
        exp_q.push_back(model(1, 0));
        drive_beat(bw[1][0], bh[1][0], st);
        drive_beat(bw[1][1], bh[1][1], st);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_data", int'(out_data), 0);
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_sb_empty", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("no_done_abort", done_cnt - d0, 0);

        // Fresh LL frame after the abort.
        for (int k = 0; k < NB; k++) fill_rand(k);
        run_frame(0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/wm_haar_block_extractor.md
WM_HAAR_BLOCK_EXTRACTOR -- requirements
Module: wm_haar_block_extractor

Interface
REQ-001 The block SHALL have parameter PIXEL_WIDTH, default 8, giving the width of input pixels and output watermark samples.
REQ-002 The block SHALL have parameter INV_GAIN, default 100, the integer reciprocal of gain k, used as an unsigned multiplier in the range 1..1023.
REQ-003 The block SHALL have parameter BLOCKS_PER_FRAME, default 16384, the number of 2x2 blocks per frame, one watermark sample each.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle frame start pulse.
REQ-007 subband_sel  in  2  coefficient to compare: 0=LL, 1=HL, 2=LH, 3=HH; latched at accepted start.
REQ-008 in_valid / in_ready  in / out  1 / 1  input beat handshake; a beat transfers when both are high.
REQ-009 wm_pix / host_pix  in / in  PIXEL_WIDTH / PIXEL_WIDTH  unsigned watermarked and host pixel at the same position.
REQ-010 out_valid / out_ready  out / in  1 / 1  output sample handshake.
REQ-011 out_data  out  PIXEL_WIDTH  extracted watermark sample.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  single-cycle pulse after the frame's last sample is accepted.

Function
REQ-014 The block SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-015 IDLE->RUN on start; a start in any other state SHALL be ignored.
REQ-016 In RUN, each block SHALL be 4 beats in order a=(r,c), b=(r,c+1), c=(r+1,c), d=(r+1,c+1), tracked by a 2-bit beat counter that wraps 3->0.
REQ-017 Coefficients SHALL be signed, PIXEL_WIDTH+3 bits wide, and computed as follows.
- LL=(a+b+c+d)>>>2
- HL=(a-b+c-d)>>>2
- LH=(a+b-c-d)>>>2
- HH=(a-b-c+d)>>>2
- >>> is an arithmetic shift that floors toward -inf, so -5>>>2 = -2.
REQ-018 The same selected coefficient SHALL be computed for both wm and host; diff = Cw - Ch, signed, PIXEL_WIDTH+4 bits.
REQ-019 The product diff*INV_GAIN SHALL be computed at full width with no overflow.
REQ-020 The product SHALL saturate: negative -> 0, above 2^PIXEL_WIDTH-1 -> 2^PIXEL_WIDTH-1, otherwise passed through.
REQ-021 The result SHALL load a one-entry output register the cycle after the block's 4th beat is accepted, setting out_valid (latency 1 cycle).
REQ-022 out_valid and out_data SHALL stay stable until out_ready is sampled high.
REQ-023 in_ready SHALL be high only in RUN, and not when beat==3 while out_valid is high and out_ready is low.
REQ-024 Accepting the 4th beat and draining the previous sample in the same cycle SHALL be allowed with no bubble.
REQ-025 Sustained throughput SHALL be 1 beat per cycle with out_ready held high.
REQ-026 A block counter SHALL count produced samples; RUN->DRAIN when block BLOCKS_PER_FRAME-1 is produced, and in_ready SHALL be low from then on.
REQ-027 DRAIN->DONE when the final sample is accepted.
REQ-028 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-029 Beat count, block count and partial sums SHALL clear on entry to RUN.
REQ-030 Inputs SHALL be ignored whenever in_ready is low.

Reset
REQ-031 While rst is high, the following SHALL hold asynchronously: state=IDLE, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, and all counters and sums = 0.
REQ-032 rst asserted mid-frame SHALL discard any partial block and pending output.
REQ-033 After reset, a new start SHALL begin a fresh frame, with no done pulse for the aborted frame.

Verification
REQ-034 The bench SHALL cover the following directed scenarios, all with INV_GAIN=4 and BLOCKS_PER_FRAME=4.
- LL, wm=100 x4, host=96 x4 -> out_data=16 one cycle after the 4th beat; done after the 4th sample is accepted.
- HH, wm a=10,b=0,c=0,d=10, host=0 -> HH=5, out_data=20.
- Saturation, LL: wm=255, host=0 -> 255; wm=0, host=200 -> 0.
- Backpressure: out_ready low for 10 cycles after the first sample -> out_data held and in_ready low at beat 3; all 4 samples correct; throughput 1 beat/cycle once out_ready is released.
- Start asserted during RUN ignored; reset asserted after 6 beats -> outputs 0 immediately; a new frame after reset gives correct results and exactly one done pulse.
